v2_filter_ctrl: RTL
===================

# v2_filter_ctrl

Sequencing and event-capture controller for the v2 trapezoidal shaping filter. It owns the filter's active-low reset, so it can flush the filter pipeline on enable. It then watches the filter output for threshold crossings and captures the peak amplitude and timestamp of each pulse. Each peak is pushed into a small event FIFO that downstream readout drains with a valid/ready handshake. It sits between the v2 filter instance and the channel readout logic, one controller per filter.

## Interface
Parameters:
- DATA_W, 16: width of the filter output sample (two's complement).
- TS_W, 32: timestamp counter width.
- FLUSH_CYCLES, 64: cycles to discard after filter reset release; must cover the filter's delay line plus pipeline depth.
- PEAK_WINDOW, 32: maximum TRACK duration in cycles before forced capture.
- DEAD_TIME, 16: cycles ignored after each capture.
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2).

Ports:
- clk, input, 1: sole clock.
- reset, input, 1: asynchronous, active-low; clears all state.
- enable, input, 1: run request, level-sensitive.
- threshold, input, DATA_W: signed trigger level, sampled every cycle.
- filt_reset_n, output, 1: drives the filter's reset input.
- filt_data, input, DATA_W: filter output_data, treated as signed.
- evt_valid, output, 1: FIFO head valid.
- evt_ready, input, 1: consumer accepts head.
- evt_amp, output, DATA_W: peak amplitude of head entry.
- evt_ts, output, TS_W: timestamp of peak sample.
- drop_cnt, output, 8: saturating count of events lost to full FIFO.
- state_o, output, 3: current state encoding (IDLE=0, FLUSH=1, ARMED=2, TRACK=3, DEAD=4).

## Operation
- Timestamp counter ts increments every cycle from 0 after reset and wraps modulo 2^TS_W. It runs regardless of enable.
- All comparisons are signed, DATA_W bits, with strict greater-than (>).

State machine:
- IDLE: filt_reset_n=0. When enable=1, go to FLUSH and clear cnt.
- FLUSH: filt_reset_n=1. cnt counts up and filt_data is ignored. When cnt==FLUSH_CYCLES-1, go to ARMED.
- ARMED: when filt_data>threshold, go to TRACK with max=filt_data, pts=ts, cnt=0.
- TRACK: each cycle, if filt_data>max, update max=filt_data and pts=ts (ties keep the earlier sample). Capture when filt_data≤threshold or cnt==PEAK_WINDOW-1. Capture pushes {max,pts} into the FIFO, then goes to DEAD with cnt=0. The sample that ends TRACK is not a peak candidate.
- DEAD: when cnt==DEAD_TIME-1, go to ARMED. Crossings during DEAD are ignored.
- enable=0 in any state: go to IDLE on the next edge. A TRACK in progress is aborted without a push. FIFO contents, drop_cnt and ts are retained.

FIFO:
- Registered storage, no bypass path.
- A pop occurs on a cycle with evt_valid&&evt_ready.
- A push while full with no pop that cycle is dropped, and drop_cnt increments, saturating at 255.
- A push while full with a simultaneous pop is accepted.
- evt_amp/evt_ts hold stable while evt_valid=1 and evt_ready=0.

## Timing
- Reset values:
  - filt_reset_n=0, state IDLE.
  - evt_valid=0, evt_amp=0, evt_ts=0.
  - drop_cnt=0, ts=0, FIFO empty.
- Reset asserted mid-operation: immediate return to reset values, including filt_reset_n=0 asynchronously.
- filt_reset_n is registered and goes 1 on the edge that enters FLUSH.
- Enable to ARMED is FLUSH_CYCLES+1 cycles: the IDLE→FLUSH edge, then FLUSH_CYCLES cycles in FLUSH.
- Capture latency: the push is written on the edge that samples the end condition. evt_valid rises on that same edge if the FIFO was empty, i.e. visible in the cycle after the end sample.
- Pop updates the head on the edge where evt_ready is sampled high. Back-to-back pops at 1 per cycle are supported.
- TRACK duration is at most PEAK_WINDOW cycles.
- The minimum spacing between pushes is DEAD_TIME+2 cycles: DEAD_TIME cycles in DEAD, at least 1 cycle in ARMED, and at least 1 cycle in TRACK before the next capture.

## Test plan
- Reset/enable: reset low, then high with enable=0 → filt_reset_n=0, state_o=0. Raise enable → filt_reset_n=1 next cycle, state_o=2 after 65 cycles with FLUSH_CYCLES=64.
- Single pulse: threshold=100, ramp filt_data 0→50→150→300→250→80 → one event, evt_amp=300, evt_ts equal to the ts of the 300 sample, DEAD entered on the 80 sample.
- Long pulse: filt_data held at 500 for 100 cycles, PEAK_WINDOW=32 → capture after 32 TRACK cycles with evt_ts equal to the first 500 sample (tie rule). After DEAD_TIME, a second event follows because the level is still above threshold.
- Backpressure: evt_ready=0, 6 pulses, FIFO_DEPTH=4 → 4 entries held stable, drop_cnt=2. Then evt_ready=1 → 4 pops in 4 consecutive cycles, in order.
- Full with simultaneous pop: FIFO full, push coincides with a pop → push accepted, drop_cnt unchanged, occupancy stays 4.
- Abort: drop enable mid-TRACK → no push, state_o=0 next cycle, filt_reset_n=0. Existing FIFO entries remain poppable. Re-enable → full FLUSH before rearm.

Source files
------------

// File: rtl/v2_filter_ctrl.sv
// rtl/v2_filter_ctrl.sv - v2 shaping filter sequencer with peak capture and event FIFO
module v2_filter_ctrl #(
    parameter int DATA_W       = 16,
    parameter int TS_W         = 32,
    parameter int FLUSH_CYCLES = 64,
    parameter int PEAK_WINDOW  = 32,
    parameter int DEAD_TIME    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] threshold,
    output logic              filt_reset_n,
    input  logic [DATA_W-1:0] filt_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_amp,
    output logic [TS_W-1:0]   evt_ts,
    output logic [7:0]        drop_cnt,
    output logic [2:0]        state_o
);

    localparam int CNT_MAX = (FLUSH_CYCLES > PEAK_WINDOW)
                           ? ((FLUSH_CYCLES > DEAD_TIME) ? FLUSH_CYCLES : DEAD_TIME)
                           : ((PEAK_WINDOW > DEAD_TIME) ? PEAK_WINDOW : DEAD_TIME);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] PEAK_LAST  = CNT_W'(PEAK_WINDOW - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_TIME - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        ARMED = 3'd2,
        TRACK = 3'd3,
        DEAD  = 3'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt, cnt_nxt;
    logic signed [DATA_W-1:0]  max_amp, max_nxt;
    logic [TS_W-1:0]           pts, pts_nxt;
    logic [TS_W-1:0]           ts;
    logic                      push_req;

    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W-1:0]  level;
    logic                      above;

    assign sample  = filt_data;
    assign level   = threshold;
    assign above   = sample > level;
    assign state_o = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        max_nxt   = max_amp;
        pts_nxt   = pts;
        push_req  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = FLUSH;
                    cnt_nxt   = '0;
                end
                FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ARMED: begin
                    if (above) begin
                        state_nxt = TRACK;
                        max_nxt   = sample;
                        pts_nxt   = ts;
                        cnt_nxt   = '0;
                    end
                end
                TRACK: begin
                    // The ending sample never competes for the peak.
                    if (!above || cnt == PEAK_LAST) begin
                        push_req  = 1'b1;
                        state_nxt = DEAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (sample > max_amp) begin
                            max_nxt = sample;
                            pts_nxt = ts;
                        end
                    end
                end
                DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        state_nxt = ARMED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            max_amp      <= '0;
            pts          <= '0;
            ts           <= '0;
            filt_reset_n <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            max_amp      <= max_nxt;
            pts          <= pts_nxt;
            ts           <= ts + 1'b1;
            filt_reset_n <= (state_nxt != IDLE);
        end
    end

    logic [DATA_W-1:0] amp_mem [FIFO_DEPTH];
    logic [TS_W-1:0]   ts_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              full, pop, push_ok, drop;

    assign evt_valid = (count != '0);
    assign full      = (count == FIFO_FULL);
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign evt_amp   = amp_mem[rd_ptr];
    assign evt_ts    = ts_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                amp_mem[i] <= '0;
                ts_mem[i]  <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                amp_mem[wr_ptr] <= max_amp;
                ts_mem[wr_ptr]  <= pts;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule
